// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one UART byte port between N requesters.
// The granted requester's handshake passes through combinationally; req_lock holds the grant for up to MAX_BURST transfers.
module uart_arbiter #(
    parameter int N         = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [N-1:0]                         req_valid,
    input  logic [N-1:0]                         req_wmask,
    input  logic [8*N-1:0]                       req_wdata,
    input  logic [N-1:0]                         req_lock,
    output logic [N-1:0]                         req_ready,
    output logic [7:0]                           req_rdata,
    output logic                                 uart_valid,
    output logic                                 uart_wmask,
    output logic [7:0]                           uart_wdata,
    input  logic                                 uart_ready,
    input  logic [7:0]                           uart_rdata,
    output logic                                 busy,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner
);

    localparam int          OW = (N > 1) ? $clog2(N) : 1;
    localparam int          BW = $clog2(MAX_BURST + 1);
    localparam int unsigned NU = N;

    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_rr;
    logic [BW-1:0]   r_burst;

    logic            w_own_valid;
    logic            w_own_wmask;
    logic            w_own_lock;
    logic [7:0]      w_own_wdata;
    logic            w_found;
    logic [OW-1:0]   w_pick;
    logic [OW-1:0]   w_rr_next;
    logic            w_done;
    logic            w_busy;

    // Select the current owner's request lines.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_wmask = 1'b0;
        w_own_lock  = 1'b0;
        w_own_wdata = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (r_owner == OW'(i)) begin
                w_own_valid = req_valid[i];
                w_own_wmask = req_wmask[i];
                w_own_lock  = req_lock[i];
                w_own_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // First pending requester scanning upward from the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (!w_found && req_valid[(32'(r_rr) + k) % NU]) begin
                w_found = 1'b1;
                w_pick  = OW'((32'(r_rr) + k) % NU);
            end
        end
    end

    assign w_busy    = (r_state == ST_OWN);
    assign w_done    = w_busy && w_own_valid && uart_ready;
    assign w_rr_next = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_done) begin
                        if (w_own_lock && ((int'(r_burst) + 1) < MAX_BURST)) begin
                            r_burst <= r_burst + 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_rr    <= w_rr_next;
                            r_burst <= '0;
                        end
                    end else if (!w_own_valid && !w_own_lock) begin
                        // An idle, unlocked owner gives the port back.
                        r_state <= ST_IDLE;
                        r_rr    <= w_rr_next;
                        r_burst <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        uart_valid = w_busy & w_own_valid;
        uart_wmask = w_busy & w_own_wmask;
        uart_wdata = w_busy ? w_own_wdata : '0;
        req_rdata  = uart_rdata;
        busy       = w_busy;
        owner      = r_owner;
        req_ready  = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            req_ready[i] = w_busy && (r_owner == OW'(i)) && req_valid[i] && uart_ready;
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: requester drivers with transaction queues, a spec-level
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_uart_arbiter;

    localparam int N  = 2;
    localparam int MB = 16;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic [N-1:0]   req_valid, req_wmask, req_lock, req_ready;
    logic [8*N-1:0] req_wdata;
    logic [7:0]     req_rdata, uart_wdata, uart_rdata;
    logic           uart_valid, uart_wmask, uart_ready, busy;
    logic [0:0]     owner;

    int n_checks = 0;
    int n_errors = 0;

    uart_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .req_lock(req_lock), .req_ready(req_ready), .req_rdata(req_rdata),
        .uart_valid(uart_valid), .uart_wmask(uart_wmask), .uart_wdata(uart_wdata),
        .uart_ready(uart_ready), .uart_rdata(uart_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant bookkeeping derived from the arbitration rules.
    int m_busy, m_owner, m_rr, m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 0; m_owner <= 0; m_rr <= 0; m_cnt <= 0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_rr + k) % N]) begin
                    m_owner <= (m_rr + k) % N;
                    m_busy  <= 1;
                    break;
                end
            end
        end else if (req_valid[m_owner] && uart_ready) begin
            if (req_lock[m_owner] && (m_cnt + 1 < MB)) begin
                m_cnt <= m_cnt + 1;
            end else begin
                m_busy <= 0; m_rr <= (m_owner + 1) % N; m_cnt <= 0;
            end
        end else if (!req_valid[m_owner] && !req_lock[m_owner]) begin
            m_busy <= 0; m_rr <= (m_owner + 1) % N; m_cnt <= 0;
        end
    end

    logic [N-1:0] e_rdy;
    always @(negedge clk) begin
        e_rdy = '0;
        if (m_busy != 0 && req_valid[m_owner] && uart_ready) e_rdy[m_owner] = 1'b1;
        check("busy",       busy,       m_busy);
        check("owner",      owner,      m_owner);
        check("uart_valid", uart_valid, (m_busy != 0) ? req_valid[m_owner] : 1'b0);
        check("uart_wmask", uart_wmask, (m_busy != 0) ? req_wmask[m_owner] : 1'b0);
        check("uart_wdata", uart_wdata, (m_busy != 0) ? req_wdata[8*m_owner +: 8] : 8'h00);
        check("req_ready",  req_ready,  e_rdy);
        check("req_rdata",  req_rdata,  uart_rdata);
    end

    // Requester drivers: each requester works through its own transaction queue.
    int unsigned txq[N][$];
    int          gap[N];
    int          gap_max = 0;
    int          ur_pct  = 100;
    logic        fixed_rd_en = 1'b1;
    logic [7:0]  fixed_rd = 8'h00;
    logic [N-1:0] done_seen;
    int          log_req[$];
    int          log_data[$];

    task automatic push(input int i, input int lock, input int wm, input int data);
        txq[i].push_back(32'((lock << 9) | (wm << 8) | (data & 255)));
    endtask

    task automatic drive_cycle();
        int unsigned tx;
        @(negedge clk);
        done_seen = req_ready;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                log_req.push_back(i);
                log_data.push_back(req_wmask[i] ? int'(req_wdata[8*i +: 8]) : int'(req_rdata));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && done_seen[i]) begin
                void'(txq[i].pop_front());
                req_valid[i] = 1'b0;
                gap[i] = int'($urandom_range(gap_max, 0));
            end
            if (!req_valid[i]) begin
                if (txq[i].size() == 0) begin
                    req_lock[i] = 1'b0;
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    tx = txq[i][0];
                    req_valid[i] = 1'b1;
                    req_wmask[i] = tx[8];
                    req_lock[i]  = tx[9];
                    req_wdata[8*i +: 8] = tx[7:0];
                end
            end
        end
        uart_ready = (int'($urandom_range(99, 0)) < ur_pct);
        uart_rdata = fixed_rd_en ? fixed_rd : 8'($urandom);
    endtask

    task automatic run_until_idle(input int maxc);
        int c = 0;
        int pend;
        do begin
            drive_cycle();
            c++;
            pend = (req_valid != '0) ? 1 : 0;
            for (int i = 0; i < N; i++) if (txq[i].size() != 0) pend = 1;
        end while (pend != 0 && c < maxc);
        check("drain_bound", pend, 0);
        drive_cycle();
        drive_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_req.delete();
        log_data.delete();
    endtask

    int run1;

    initial begin
        req_valid = '0; req_wmask = '0; req_wdata = '0; req_lock = '0;
        uart_ready = 1'b0; uart_rdata = 8'h00;
        for (int i = 0; i < N; i++) gap[i] = 0;

        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_uart_valid", uart_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_owner", owner, 0);
        check("rst_uart_wdata", uart_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick();

        // Contention from rr_ptr=0, then again after requester 1 was served.
        push(0, 0, 1, 8'h11); push(1, 0, 1, 8'h22);
        run_until_idle(20);
        check("t2_count", log_req.size(), 2);
        check("t2_first_req", log_req[0], 0);
        check("t2_first_data", log_data[0], 8'h11);
        check("t2_second_req", log_req[1], 1);
        check("t2_second_data", log_data[1], 8'h22);
        clear_log();
        push(0, 0, 1, 8'h33); push(1, 0, 1, 8'h44);
        run_until_idle(20);
        check("t2_again_first_req", log_req[0], 0);
        check("t2_again_first_data", log_data[0], 8'h33);
        clear_log();

        // Single write with exact grant latency.
        req_valid = 2'b01; req_wmask = 2'b01; req_wdata = 16'h0041; uart_ready = 1'b1;
        #1;
        check("t1_idle_no_valid", uart_valid, 0);
        check("t1_idle_no_ready", req_ready, 0);
        tick();
        check("t1_grant_busy", busy, 1);
        check("t1_grant_owner", owner, 0);
        check("t1_uart_valid", uart_valid, 1);
        check("t1_uart_wdata", uart_wdata, 8'h41);
        check("t1_req_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        #1;
        check("t1_released", busy, 0);
        check("t1_ready_low", req_ready, 0);

        // Reads from both with rr_ptr=1: requester 1 served first.
        fixed_rd = 8'h5A;
        push(0, 0, 0, 0); push(1, 0, 0, 0);
        run_until_idle(20);
        check("t5_first_req", log_req[0], 1);
        check("t5_first_rdata", log_data[0], 8'h5A);
        check("t5_second_req", log_req[1], 0);
        clear_log();

        // Locked burst capped at MAX_BURST.
        for (int k = 0; k < 20; k++) push(1, 1, 1, k);
        push(0, 0, 1, 8'hAA);
        run_until_idle(100);
        run1 = 0;
        while (run1 < log_req.size() && log_req[run1] == 1) run1++;
        check("t3_burst_len", run1, MB);
        check("t3_total", log_req.size(), 21);
        check("t3_last_burst_data", log_data[15], 15);
        check("t3_waiter_req", log_req[16], 0);
        check("t3_waiter_data", log_data[16], 8'hAA);
        check("t3_resume_data", log_data[17], 16);
        clear_log();

        // Voluntary release: owner drops valid right after grant.
        uart_ready = 1'b0;
        req_valid = 2'b01; req_wmask = 2'b01; req_wdata = 16'h0099;
        tick();
        req_valid = 2'b10; req_wdata = 16'h9900; req_wmask = 2'b10;
        #1;
        check("t4_granted", busy, 1);
        check("t4_no_valid", uart_valid, 0);
        tick();
        check("t4_released", busy, 0);
        tick();
        check("t4_regrant_busy", busy, 1);
        check("t4_regrant_owner", owner, 1);
        check("t4_regrant_valid", uart_valid, 1);
        uart_ready = 1'b1;
        tick();
        req_valid = '0; uart_ready = 1'b0;
        #1;
        check("t4_done", busy, 0);

        // Asynchronous reset while owner 1 is mid-handshake.
        req_valid = 2'b01; req_wmask = 2'b01; req_wdata = 16'h0077; uart_ready = 1'b1;
        tick();
        tick();
        req_valid = 2'b10; req_wmask = 2'b10; req_wdata = 16'h8800; uart_ready = 1'b0;
        tick();
        check("t6_owner", owner, 1);
        check("t6_valid", uart_valid, 1);
        uart_ready = 1'b1;
        #1;
        check("t6_ready", req_ready, 2'b10);
        #1 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", uart_valid, 0);
        check("t6_rst_ready", req_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_owner", owner, 0);
        uart_ready = 1'b0;
        req_valid = 2'b11; req_wmask = 2'b11;
        @(negedge clk);
        #2 reset_n = 1'b1;
        tick();
        check("t6_post_owner", owner, 0);
        check("t6_post_busy", busy, 1);
        req_valid = '0;
        tick();
        check("t6_post_release", busy, 0);

        // Randomized traffic against the model.
        gap_max = 2; ur_pct = 60; fixed_rd_en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            for (int i = 0; i < N; i++) begin
                push(i, ($urandom_range(3, 0) == 0) ? 1 : 0,
                     int'($urandom_range(1, 0)), int'($urandom_range(255, 0)));
            end
        end
        run_until_idle(3000);
        check("rand_completions", log_req.size(), 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
Shares the single UART byte port (valid/ready/wmask/wdata/rdata) between N requesters, e.g. core load/store unit and debug/boot loader. Round-robin grant with optional lock, so a requester can hold the port for a multi-byte message, capped at MAX_BURST transfers. Sits between requesters and the uart block. Passes the uart handshake through combinationally once granted.

Parameters:
N, 2, number of requesters (2..8)
MAX_BURST, 16, max completed transfers per grant while req_lock held (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  N  per-requester transfer request
req_wmask  input  N  per-requester direction: 1 = write (tx), 0 = read (rx)
req_wdata  input  8*N  per-requester write byte; requester i at bits [8i+7:8i]
req_lock  input  N  hold grant after current transfer
req_ready  output  N  per-requester handshake complete
req_rdata  output  8  received byte, broadcast; valid only to owner when its req_ready=1
uart_valid  output  1  to uart valid
uart_wmask  output  1  to uart wmask
uart_wdata  output  8  to uart wdata
uart_ready  input  1  from uart ready
uart_rdata  input  8  from uart rdata
busy  output  1  grant held (state OWN)
owner  output  clog2(N) (min 1)  current/last owner index

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - All outputs drop immediately: uart_valid=0, uart_wmask=0, uart_wdata=0, req_ready=0, busy=0.
- States: IDLE, OWN.
- IDLE:
  - uart_valid=0; req_ready=0.
  - If any req_valid, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod N.
  - Register it as owner; go to OWN next edge.
  - Arbitration latency is exactly 1 cycle from req_valid to grant; no transfer can complete in IDLE.
- OWN, combinational passthrough:
  - uart_valid=req_valid[owner], uart_wmask=req_wmask[owner], uart_wdata=req_wdata[owner].
  - req_ready[owner]=uart_ready & req_valid[owner]; all other req_ready bits=0.
  - req_rdata=uart_rdata always.
  - Non-owners see uart_valid only via the owner; their requests wait.
- Transfer completes on req_valid[owner] & uart_ready at a clk edge. On completion:
  - If req_lock[owner]=1 and burst_cnt+1 < MAX_BURST: stay OWN, burst_cnt += 1.
  - Else: go IDLE, rr_ptr=(owner+1) mod N, burst_cnt=0.
- Voluntary release:
  - Condition: in OWN, req_valid[owner]=0 and req_lock[owner]=0 with no completion.
  - Action: go IDLE, rr_ptr=(owner+1) mod N, burst_cnt=0.
  - This is required so an idle owner cannot strand the port.
- Lock with req_valid[owner]=0: stay OWN, burst_cnt unchanged. Owner may idle while holding the lock.
- Requester contract: once req_valid is asserted to the owner path, it holds valid/wmask/wdata stable until req_ready. The arbiter does not re-register the payload.
- Read path: uart_valid with wmask=0 is forwarded only from the owner. The uart consumes the rx byte only on an owner read, so no byte is lost to a non-owner.
- burst_cnt width: clog2(MAX_BURST+1). Counter never wraps; the cap forces release at MAX_BURST completions.
- MAX_BURST=1: lock has no effect; every completion releases.
- busy = (state==OWN). owner holds its value in IDLE until the next grant.
- Reset mid-transfer: the grant is lost and uart_valid drops asynchronously. The requester retries after reset.

Test Plan:
1. Single requester 0 write, wdata=0x41, uart_ready=1 → grant the cycle after req_valid. Then uart_valid=1, uart_wdata=0x41, req_ready[0]=1 for one cycle. Then IDLE, rr_ptr=1.
2. Both requesters valid at once (writes 0x11, 0x22), rr_ptr=0 → completions in order: 0x11 by requester 0, then 0x22 by requester 1. req_ready never asserted for the non-owner. Next contention grants requester 0 first.
3. Requester 1 req_lock=1 with 20 back-to-back writes, requester 0 waiting, MAX_BURST=16 → exactly 16 completions for requester 1. Then release; requester 0 is granted next.
4. Requester 0 granted, then drops req_valid with lock=0 before uart_ready → returns to IDLE next edge, no uart_valid pulse. Pending requester 1 is granted on the following cycle.
5. Read: uart_rdata=0x5A, uart_ready=1 for read, requester 1 owner with wmask=0 → req_ready[1]=1, req_rdata=0x5A. Requester 0's concurrent read does not reach uart_valid.
6. Assert reset_n=0 mid-OWN with uart_valid=1 → uart_valid, req_ready and busy go 0 without a clk edge. After release, state=IDLE and rr_ptr=0.
